// File: rtl/quad_step_decoder_pkg.sv
// Shared constants for the quadrature step decoder: Gray states, direction
// encodings, the decoder state machine enum and the forward-step helper.
package quad_pkg;

    localparam logic [1:0] S00 = 2'b00;
    localparam logic [1:0] S10 = 2'b10;
    localparam logic [1:0] S11 = 2'b11;
    localparam logic [1:0] S01 = 2'b01;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    typedef enum logic {INIT, TRACK} state_t;

    // Successor of s when A leads B (the "up" direction).
    function automatic logic [1:0] next_up(input logic [1:0] s);
        unique case (s)
            S00:     next_up = S10;
            S10:     next_up = S11;
            S11:     next_up = S01;
            default: next_up = S00;
        endcase
    endfunction

endpackage

// File: rtl/quad_step_decoder_if.sv
// Encoder-side bus of the quadrature decoder: raw A/B in, step/direction/error out.
// o_err_cnt exists only when QUAD_ERR_CNT_EN is defined.
interface quad_step_decoder_if;
    logic       i_a;
    logic       i_b;
    logic       o_en;
    logic       o_up_down;
    logic       o_err;
`ifdef QUAD_ERR_CNT_EN
    logic [7:0] o_err_cnt;

    modport master (output i_a, i_b, input o_en, o_up_down, o_err, o_err_cnt);
    modport slave  (input i_a, i_b, output o_en, o_up_down, o_err, o_err_cnt);
`else
    modport master (output i_a, i_b, input o_en, o_up_down, o_err);
    modport slave  (input i_a, i_b, output o_en, o_up_down, o_err);
`endif
endinterface

// File: rtl/quad_step_decoder_glitch_filter.sv
// One encoder channel: SYNC_STAGES-flop synchroniser followed by a filter that
// accepts a new level only after FILT_CYCLES consecutive disagreeing cycles.
module quad_glitch_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 4,
    parameter int FILT_W      = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic filt,
    output logic stable
);

    logic [SYNC_STAGES-1:0] sync;
    logic [FILT_W-1:0]      cnt;
    logic                   sync_out;

    assign sync_out = sync[SYNC_STAGES-1];
    assign stable   = (sync_out == filt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            filt <= 1'b0;
            cnt  <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], raw};
            if (stable) begin
                cnt <= '0;
            end else if (cnt == FILT_W'(FILT_CYCLES - 1)) begin
                filt <= sync_out;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature A/B front end: filtered channels feed an INIT/TRACK decoder that
// emits step pulses, a direction level and illegal-transition pulses.
// Optional saturating error counter enabled by QUAD_ERR_CNT_EN.
module quad_step_decoder
    import quad_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 4,
    parameter int FILT_W      = 3
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    quad_step_decoder_if.slave  bus
);

    logic [1:0]        raw, filt, stable, prev;
    state_t            state, state_nxt;
    logic [FILT_W-1:0] stab_cnt, stab_nxt;
    logic              en, en_nxt, err, err_nxt, up_down, dir_nxt;

    assign raw = {bus.i_a, bus.i_b};

    for (genvar i = 0; i < 2; i++) begin : g_ch
        quad_glitch_filter #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_CYCLES (FILT_CYCLES),
            .FILT_W      (FILT_W)
        ) u_filt (
            .clk    (i_clk),
            .rst_n  (i_rst_n),
            .raw    (raw[i]),
            .filt   (filt[i]),
            .stable (stable[i])
        );
    end

    always_comb begin
        state_nxt = state;
        stab_nxt  = stab_cnt;
        en_nxt    = 1'b0;
        err_nxt   = 1'b0;
        dir_nxt   = up_down;
        unique case (state)
            INIT: begin
                // Wait until both channels have been quiet long enough to trust filt.
                if (&stable) begin
                    if (stab_cnt == FILT_W'(FILT_CYCLES - 1)) begin
                        state_nxt = TRACK;
                        stab_nxt  = '0;
                    end else begin
                        stab_nxt = stab_cnt + 1'b1;
                    end
                end else begin
                    stab_nxt = '0;
                end
            end
            default: begin
                if (filt != prev) begin
                    if (filt == next_up(prev)) begin
                        en_nxt  = 1'b1;
                        dir_nxt = DIR_UP;
                    end else if (prev == next_up(filt)) begin
                        en_nxt  = 1'b1;
                        dir_nxt = DIR_DN;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= INIT;
            stab_cnt <= '0;
            prev     <= S00;
            en       <= 1'b0;
            err      <= 1'b0;
            up_down  <= DIR_UP;
        end else begin
            state    <= state_nxt;
            stab_cnt <= stab_nxt;
            prev     <= filt;
            en       <= en_nxt;
            err      <= err_nxt;
            up_down  <= dir_nxt;
        end
    end

    assign bus.o_en      = en;
    assign bus.o_err     = err;
    assign bus.o_up_down = up_down;

`ifdef QUAD_ERR_CNT_EN
    logic [7:0] err_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            err_cnt <= '0;
        else if (err_nxt && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 1'b1;
    end

    assign bus.o_err_cnt = err_cnt;
`endif

endmodule

// File: tb/tb_quad_step_decoder.sv
// Scoreboard bench for quad_step_decoder: stimulus pushes expected step/error
// events computed from Gray-cycle positions; a monitor pops them on every pulse.
module tb_quad_step_decoder;

    localparam int LAT  = 7;   // SYNC_STAGES + FILT_CYCLES + 1
    localparam int FILT = 4;

    typedef struct {
        bit is_err;
        bit dir;
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    ev_t  q[$];
    logic [1:0] acc;
    bit   mdir;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    quad_step_decoder_if bus();

    quad_step_decoder dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    function automatic int gidx(input logic [1:0] v);
        case (v)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] gval(input int i);
        case (i % 4)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive v for len cycles; a hold of at least FILT cycles that moves away from
    // the accepted state yields one event LAT edges after the change.
    task automatic apply(input logic [1:0] v, input int len);
        ev_t e;
        int d;
        bus.i_a = v[1];
        bus.i_b = v[0];
        if (len >= FILT && v != acc) begin
            d = (gidx(v) - gidx(acc) + 4) % 4;
            e.cyc = cyc + LAT;
            if (d == 2) begin
                e.is_err = 1'b1;
            end else begin
                e.is_err = 1'b0;
                mdir = (d == 1);
            end
            e.dir = mdir;
            q.push_back(e);
            acc = v;
        end
        repeat (len) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_en"},  int'(bus.o_en), 0);
        check({tag, "_dir"}, int'(bus.o_up_down), 1);
        check({tag, "_err"}, int'(bus.o_err), 0);
`ifdef QUAD_ERR_CNT_EN
        check({tag, "_errcnt"}, int'(bus.o_err_cnt), 0);
`endif
    endtask

    // Monitor: every pulse must match the oldest expected event.
    initial begin
        ev_t e;
        int exp_cnt;
        exp_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_cnt = 0;
            end else begin
                if (q.size() > 0 && q[0].cyc < cyc) begin
                    e = q.pop_front();
                    check("missed_pulse", cyc, e.cyc);
                end
                if (bus.o_en || bus.o_err) begin
                    if (bus.o_en && bus.o_err) check("en_err_both", 1, 0);
                    if (q.size() == 0) begin
                        check("unexpected_pulse", cyc, -1);
                    end else begin
                        e = q.pop_front();
                        check("pulse_cycle", cyc, e.cyc);
                        check("pulse_is_err", int'(bus.o_err), int'(e.is_err));
                        check("up_down", int'(bus.o_up_down), int'(e.dir));
`ifdef QUAD_ERR_CNT_EN
                        if (e.is_err) begin
                            exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
                            check("err_cnt", int'(bus.o_err_cnt), exp_cnt);
                        end
`endif
                    end
                end
            end
        end
    end

    initial begin
        int r, len;
        logic [1:0] flip;
        bus.i_a = 1'b1;
        bus.i_b = 1'b1;
        acc  = 2'b11;
        mdir = 1'b1;

        // 1: reset with a=b=1, INIT settles to 11 silently
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // 2: full up cycle, each state held 10 cycles (first two reach 00)
        apply(2'b01, 10);
        apply(2'b00, 10);
        apply(2'b10, 10);
        apply(2'b11, 10);
        apply(2'b01, 10);
        apply(2'b00, 10);

        // 3: reverse sequence
        apply(2'b01, 10);
        apply(2'b11, 10);
        apply(2'b10, 10);

        // 4: back to 00, then a 3-cycle A glitch must vanish
        apply(2'b00, 10);
        apply(2'b10, 3);
        apply(2'b00, 10);

        // 5: double transitions, 300 of them to saturate the counter
        for (int i = 0; i < 300; i++)
            apply((i % 2 == 0) ? 2'b11 : 2'b00, 5);

        // 6: reset in the middle of a filter count
        bus.i_a = 1'b1;
        bus.i_b = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst_async");
        @(negedge clk);
        check_reset_vals("midrst_hold");
        rst_n = 1'b1;
        acc  = 2'b10;
        mdir = 1'b1;
        repeat (25) @(negedge clk);
        apply(2'b11, 10);

        // Randomized mix of steps, glitches, double changes and idle holds
        for (int i = 0; i < 120; i++) begin
            r = $urandom_range(0, 9);
            if (r < 6) begin
                len = $urandom_range(FILT, 12);
                apply(gval(gidx(acc) + (($urandom_range(0, 1) == 1) ? 1 : 3)), len);
            end else if (r < 8) begin
                flip = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
                apply(acc ^ flip, $urandom_range(1, FILT - 1));
                apply(acc, $urandom_range(FILT, 10));
            end else if (r == 8) begin
                apply(acc ^ 2'b11, $urandom_range(FILT, 10));
            end else begin
                apply(acc, $urandom_range(1, 8));
            end
        end

        repeat (20) @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
